// File: rtl/nn_pkg.sv
// Shared helpers for the neural-network datapath blocks: bit-width math,
// signed saturation bounds and packed-lane addressing.
package nn_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Largest value representable in an n-bit two's complement word.
  function automatic longint sat_max(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  // Smallest value representable in an n-bit two's complement word.
  function automatic longint sat_min(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

  // The accumulator must at least hold one full beat of products without wrap.
  function automatic bit acc_w_ok(input int n, input int in_ch, input int acc_w);
    return acc_w >= 2 * n + clog2(in_ch);
  endfunction

  // Low bit index of lane 'lane' in a vector packed with w-bit lanes.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // Post-accumulate arithmetic width: room for acc, a 32-bit bias and the
  // rounding increment without overflow.
  function automatic int t_width(input int acc_w);
    return ((acc_w > 32) ? acc_w : 32) + 2;
  endfunction

endpackage

// File: rtl/sum_tree.sv
// Combinational signed reduction of IN_CH packed lanes into one wider sum.
module sum_tree
  import nn_pkg::*;
#(
  parameter int IN_CH = 8,
  parameter int W_IN  = 32,
  parameter int W_OUT = 40
) (
  input  logic [IN_CH*W_IN-1:0]  din_i,
  output logic signed [W_OUT-1:0] sum_o
);

  // Sign-extend each lane to the output width and add them up.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < IN_CH; i++) begin
      sum_o = sum_o + W_OUT'($signed(din_i[lane_lo(i, W_IN) +: W_IN]));
    end
  end

endmodule

// File: rtl/pconv_acc_unit.sv
// Pointwise (1x1) convolution unit. Multiplies IN_CH lane pairs per beat,
// accumulates beats until in_last, then applies bias, rounding shift, ReLU
// and saturation. The whole pipe advances together under one enable, so a
// stalled output freezes every stage and in_ready simply mirrors that enable.
module pconv_acc_unit
  import nn_pkg::*;
#(
  parameter int N     = 16,
  parameter int IN_CH = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [IN_CH-1:0]   in_keep,
  input  logic [IN_CH*N-1:0] input_din,
  input  logic [IN_CH*N-1:0] weight_din,
  input  logic [31:0]        bias_din,
  input  logic [4:0]         shift_din,
  input  logic               relu_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       conv_dout,
  output logic               out_sat
);

  localparam int PW = 2 * N;
  localparam int TW = t_width(ACC_W);
  localparam logic signed [TW-1:0] SAT_HI = TW'(sat_max(N));
  localparam logic signed [TW-1:0] SAT_LO = TW'(sat_min(N));

  if (IN_CH < 1) begin : g_in_ch_chk
    $error("pconv_acc_unit: IN_CH must be at least 1");
  end
  if (!acc_w_ok(N, IN_CH, ACC_W)) begin : g_acc_w_chk
    $error("pconv_acc_unit: ACC_W too narrow for one beat of products");
  end

  logic adv;

  // S1: products and per-beat controls
  logic                     s1_valid_q, s1_last_q, s1_relu_q;
  logic [IN_CH*PW-1:0]      s1_prod_q, prod_d;
  logic [31:0]              s1_bias_q;
  logic [4:0]               s1_shift_q;

  // S2: lane sum
  logic                     s2_valid_q, s2_last_q, s2_relu_q;
  logic signed [ACC_W-1:0]  s2_sum_q, sum_d;
  logic [31:0]              s2_bias_q;
  logic [4:0]               s2_shift_q;

  // S3: accumulator
  logic                     s3_valid_q, s3_relu_q, first_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]              s3_bias_q;
  logic [4:0]               s3_shift_q;

  // S4: biased and rounded value, then the output register
  logic                     s4_valid_q, s4_relu_q;
  logic signed [TW-1:0]     s4_t_q, t_d, rnd_d, sh_d;
  logic [4:0]               s4_shift_q;
  logic                     out_valid_q, out_sat_q, sat_d;
  logic [N-1:0]             dout_q, dout_d;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign conv_dout = dout_q;
  assign out_sat   = out_sat_q;

  // Lane products, zeroed where the lane is not kept.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < IN_CH; i++) begin
      if (in_keep[i]) begin
        prod_d[lane_lo(i, PW) +: PW] =
          PW'($signed(input_din[lane_lo(i, N) +: N])) *
          PW'($signed(weight_din[lane_lo(i, N) +: N]));
      end
    end
  end

  sum_tree #(
    .IN_CH (IN_CH),
    .W_IN  (PW),
    .W_OUT (ACC_W)
  ) u_sum_tree (
    .din_i (s1_prod_q),
    .sum_o (sum_d)
  );

  // S1 register: capture products and the beat's control fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_prod_q  <= '0;
      s1_bias_q  <= '0;
      s1_shift_q <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      s1_relu_q  <= relu_en;
      s1_prod_q  <= prod_d;
      s1_bias_q  <= bias_din;
      s1_shift_q <= shift_din;
    end
  end

  // S2 register: capture the reduced beat sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_relu_q  <= 1'b0;
      s2_sum_q   <= '0;
      s2_bias_q  <= '0;
      s2_shift_q <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_relu_q  <= s1_relu_q;
      s2_sum_q   <= sum_d;
      s2_bias_q  <= s1_bias_q;
      s2_shift_q <= s1_shift_q;
    end
  end

  // A first beat restarts the sum so back-to-back pixels never carry over.
  always_comb begin
    acc_d = (first_q ? '0 : acc_q) + s2_sum_q;
  end

  // S3 register: accumulate valid beats; latch the closing beat's controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_relu_q  <= 1'b0;
      first_q    <= 1'b1;
      acc_q      <= '0;
      s3_bias_q  <= '0;
      s3_shift_q <= '0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        acc_q   <= acc_d;
        first_q <= s2_last_q;
        if (s2_last_q) begin
          s3_relu_q  <= s2_relu_q;
          s3_bias_q  <= s2_bias_q;
          s3_shift_q <= s2_shift_q;
        end
      end
    end
  end

  // Bias plus a half-LSB increment so the later shift rounds half up.
  always_comb begin
    rnd_d = '0;
    if (s3_shift_q != 5'd0) rnd_d = TW'(1) <<< (s3_shift_q - 5'd1);
    t_d = TW'(acc_q) + TW'($signed(s3_bias_q)) + rnd_d;
  end

  // S4 first half: register the biased, rounding-adjusted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s4_valid_q <= 1'b0;
      s4_relu_q  <= 1'b0;
      s4_t_q     <= '0;
      s4_shift_q <= '0;
    end else if (adv) begin
      s4_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        s4_t_q     <= t_d;
        s4_shift_q <= s3_shift_q;
        s4_relu_q  <= s3_relu_q;
      end
    end
  end

  // Shift, then ReLU, then clamp; a ReLU zero is not flagged as saturation.
  always_comb begin
    sh_d   = s4_t_q >>> s4_shift_q;
    dout_d = '0;
    sat_d  = 1'b0;
    if (s4_relu_q && sh_d[TW-1]) begin
      dout_d = '0;
    end else if (sh_d > SAT_HI) begin
      dout_d = SAT_HI[N-1:0];
      sat_d  = 1'b1;
    end else if (sh_d < SAT_LO) begin
      dout_d = SAT_LO[N-1:0];
      sat_d  = 1'b1;
    end else begin
      dout_d = sh_d[N-1:0];
    end
  end

  // Output register: holds the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s4_valid_q;
      if (s4_valid_q) begin
        dout_q    <= dout_d;
        out_sat_q <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_pconv_acc_unit.sv
// Scoreboard bench for pconv_acc_unit: the stimulus side pushes expected
// pixels from an arithmetic reference model, a negedge monitor pops them.
module tb_pconv_acc_unit;

  localparam int N     = 16;
  localparam int IN_CH = 4;
  localparam int ACC_W = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [IN_CH-1:0]   in_keep;
  logic [IN_CH*N-1:0] input_din;
  logic [IN_CH*N-1:0] weight_din;
  logic [31:0]        bias_din;
  logic [4:0]         shift_din;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       conv_dout;
  logic               out_sat;

  pconv_acc_unit #(.N(N), .IN_CH(IN_CH), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_keep    (in_keep),
    .input_din  (input_din),
    .weight_din (weight_din),
    .bias_din   (bias_din),
    .shift_din  (shift_din),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .conv_dout  (conv_dout),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  int     vec_cnt  = 0;
  int     miss_cnt = 0;
  int     exp_dout_q[$];
  bit     exp_sat_q[$];
  longint m_acc   = 0;
  bit     m_first = 1'b1;

  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;
  bit rnd_bit     = 1'b1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end
  assign out_ready = rand_ready ? rnd_bit : ready_force;

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
  endtask

  // Reference: whole-pixel arithmetic on 64-bit integers.
  task automatic model_beat(input int a[IN_CH], input int w[IN_CH],
                            input logic [IN_CH-1:0] keep, input bit last,
                            input int bias, input int shift, input bit relu);
    longint s;
    longint t;
    bit     sat;
    s = 0;
    for (int i = 0; i < IN_CH; i++)
      if (keep[i]) s += longint'(a[i]) * longint'(w[i]);
    m_acc   = m_first ? s : m_acc + s;
    m_acc   = (m_acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
    m_first = last;
    if (last) begin
      t = m_acc + longint'(bias);
      if (shift > 0) t += longint'(1) <<< (shift - 1);
      t = t >>> shift;
      if (relu && t < 0) t = 0;
      sat = 1'b0;
      if (t > 32767) begin
        t = 32767;
        sat = 1'b1;
      end else if (t < -32768) begin
        t = -32768;
        sat = 1'b1;
      end
      exp_dout_q.push_back(int'(t));
      exp_sat_q.push_back(sat);
    end
  endtask

  task automatic send_beat(input int a[IN_CH], input int w[IN_CH],
                           input logic [IN_CH-1:0] keep, input bit last,
                           input int bias, input int shift, input bit relu,
                           input int gap);
    bit acc;
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    for (int i = 0; i < IN_CH; i++) begin
      input_din[i*N +: N]  = a[i][N-1:0];
      weight_din[i*N +: N] = w[i][N-1:0];
    end
    in_keep   = keep;
    in_last   = last;
    bias_din  = bias;
    shift_din = 5'(shift);
    relu_en   = relu;
    in_valid  = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
      if (!acc && n > 200) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
        report();
        $finish;
      end
    end
    model_beat(a, w, keep, last, bias, shift, relu);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_uni(input int av, input int wv, input logic [IN_CH-1:0] keep,
                          input bit last, input int bias, input int shift,
                          input bit relu);
    int a[IN_CH];
    int w[IN_CH];
    for (int i = 0; i < IN_CH; i++) begin
      a[i] = av;
      w[i] = wv;
    end
    send_beat(a, w, keep, last, bias, shift, relu, 0);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    vec_cnt++;
    if (!out_valid) begin
      miss_cnt++;
      $display("FAIL wait_out_valid: out_valid=%0b, required 1", out_valid);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_dout_q.size() > 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    vec_cnt++;
    if (exp_dout_q.size() > 0) begin
      miss_cnt++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_dout_q.size());
    end
  endtask

  // Monitor: stability while stalled, in_ready during stall, scoreboard pop.
  bit         hold_v = 1'b0;
  logic [N-1:0] hold_d;
  logic       hold_s;
  always @(negedge clk) begin
    int e;
    bit es;
    if (rst) begin
      hold_v = 1'b0;
    end else if (out_valid) begin
      if (hold_v) begin
        vec_cnt++;
        if (conv_dout !== hold_d || out_sat !== hold_s) begin
          miss_cnt++;
          $display("FAIL stall_stable: dout=%0d sat=%0b, required dout=%0d sat=%0b",
                   $signed(conv_dout), out_sat, $signed(hold_d), hold_s);
        end
      end
      if (!out_ready) begin
        vec_cnt++;
        if (in_ready !== 1'b0) begin
          miss_cnt++;
          $display("FAIL stall_in_ready: in_ready=%0b, required 0", in_ready);
        end
        hold_v = 1'b1;
        hold_d = conv_dout;
        hold_s = out_sat;
      end else begin
        hold_v = 1'b0;
        vec_cnt++;
        if (exp_dout_q.size() == 0) begin
          miss_cnt++;
          $display("FAIL unexpected_out: dout=%0d, required no output", $signed(conv_dout));
        end else begin
          e  = exp_dout_q.pop_front();
          es = exp_sat_q.pop_front();
          if (conv_dout !== 16'(e) || out_sat !== es) begin
            miss_cnt++;
            $display("FAIL result: dout=%0d sat=%0b, required dout=%0d sat=%0b",
                     $signed(conv_dout), out_sat, e, es);
          end
        end
      end
    end
  end

  initial begin
    int a[IN_CH];
    int w[IN_CH];
    int nb;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_keep    = '0;
    input_din  = '0;
    weight_din = '0;
    bias_din   = '0;
    shift_din  = '0;
    relu_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || conv_dout !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_state: valid=%0b dout=%0d sat=%0b rdy=%0b, required 0 0 0 1",
               out_valid, conv_dout, out_sat, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat with latency check: 4*65536 >> 8 = 1024.
    send_uni(256, 256, 4'b1111, 1'b1, 0, 8, 1'b0);
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL latency_early: out_valid=%0b after 3 edges, required 0", out_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b1) begin
      miss_cnt++;
      $display("FAIL latency: out_valid=%0b after 4 edges, required 1", out_valid);
    end
    @(posedge clk);
    #1;

    // Three-beat pixel (3072) followed immediately by a one-beat pixel (1024).
    send_uni(256, 256, 4'b1111, 1'b0, 0, 8, 1'b0);
    send_uni(256, 256, 4'b1111, 1'b0, 0, 8, 1'b0);
    send_uni(256, 256, 4'b1111, 1'b1, 0, 8, 1'b0);
    send_uni(256, 256, 4'b1111, 1'b1, 0, 8, 1'b0);

    // Single kept negative lane: -256, then ReLU gives 0 without saturation.
    send_uni(-256, 256, 4'b0001, 1'b1, 0, 8, 1'b0);
    send_uni(-256, 256, 4'b0001, 1'b1, 0, 8, 1'b1);

    // Saturation at both rails.
    send_uni(32767, 32767, 4'b1111, 1'b1, 0, 0, 1'b0);
    send_uni(32767, -32767, 4'b1111, 1'b1, 0, 0, 1'b0);

    // Rounding half up through the bias path: 384/256 -> 2, -384/256 -> -1.
    send_uni(1000, 1000, 4'b0000, 1'b1, 384, 8, 1'b0);
    send_uni(1000, 1000, 4'b0000, 1'b1, -384, 8, 1'b0);
    wait_drain();

    // Backpressure: two pixels queue up behind a 3-cycle stall.
    ready_force = 1'b0;
    send_uni(256, 256, 4'b1111, 1'b1, 0, 8, 1'b0);
    send_uni(512, 256, 4'b1111, 1'b1, 0, 8, 1'b0);
    wait_out_valid();
    repeat (3) @(posedge clk);
    #1;
    ready_force = 1'b1;
    wait_drain();

    // Reset with one finished pixel waiting and a partial pixel in flight.
    ready_force = 1'b0;
    send_uni(256, 256, 4'b1111, 1'b1, 0, 8, 1'b0);
    send_uni(256, 256, 4'b1111, 1'b0, 0, 8, 1'b0);
    send_uni(256, 256, 4'b1111, 1'b0, 0, 8, 1'b0);
    wait_out_valid();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || conv_dout !== '0 || out_sat !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_mid: valid=%0b dout=%0d sat=%0b, required 0 0 0",
               out_valid, conv_dout, out_sat);
    end
    exp_dout_q.delete();
    exp_sat_q.delete();
    m_acc   = 0;
    m_first = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    send_uni(256, 256, 4'b1111, 1'b1, 0, 8, 1'b0);
    wait_drain();

    // Randomized pixels with bubbles and random backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < IN_CH; i++) begin
          a[i] = int'($signed(16'($urandom)));
          w[i] = int'($signed(16'($urandom)));
        end
        send_beat(a, w, 4'($urandom), (b == nb - 1),
                  int'($urandom) >>> $urandom_range(4, 31),
                  $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2));
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (5) @(posedge clk);

    report();
    $finish;
  end

endmodule

// File: doc/pconv_acc_unit.md
Name: pconv_acc_unit

Overview:
Pointwise (1x1) convolution unit, next generation of the per-pixel MAC unit. Each beat carries IN_CH signed input/weight lane pairs. The unit accumulates an arbitrary number of beats per output pixel, framed by in_last, so channel counts above IN_CH need no extra hardware. It then applies bias, rounding arithmetic shift, optional ReLU and signed saturation, and emits one N-bit activation. It uses a 4-stage pipeline with valid/ready on both sides and sits between the feature-map line buffer and the activation writer.

Parameters:
N, 16, data/weight/output width, signed two's complement
IN_CH, 8, lanes (multipliers) per beat, >=1
ACC_W, 40, accumulator width; must be >= 2N+clog2(IN_CH)+clog2(max beats per pixel)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready at clk edge
in_last  in  1  final beat of current output pixel
in_keep  in  IN_CH  per-lane enable; lane product forced to 0 when low
input_din  in  IN_CH*N  packed inputs, lane i at [(i+1)*N-1:i*N]
weight_din  in  IN_CH*N  packed weights, same packing
bias_din  in  32  signed bias, added at accumulator scale
shift_din  in  5  right-shift amount 0..31
relu_en  in  1  1 = clamp negatives to 0
out_valid  out  1  result valid
out_ready  in  1  downstream ready
conv_dout  out  N  signed result
out_sat  out  1  result was saturated (qualified by out_valid)

Behaviour:
- Reset (async assert, sync release): all stage valids 0, accumulator 0, first-beat flag 1, out_valid=0, conv_dout=0, out_sat=0.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. When adv=0, every stage holds.
- S1: register the IN_CH signed products (2N bits each), masked by in_keep, plus valid and last. bias/shift/relu_en are sampled with each beat and carried down the pipe; the values on the last beat are the ones used.
- S2: register the sign-extended sum of S1 products at ACC_W.
- S3: on a valid S2 beat, acc <= (first ? 0 : acc) + sum, and first <= last. On last, mark the result valid for S4. acc wraps at ACC_W; sizing is the integrator's responsibility.
- S4 (output register): t = acc + sext(bias); if shift>0, t += 1<<(shift-1) (round half up); t >>>= shift (arithmetic). If relu_en and t<0, t=0. Saturate to [-2^(N-1), 2^(N-1)-1]; out_sat=1 if clamped (ReLU clamp is not saturation).
- Latency: last beat accepted at edge k, out_valid high after edge k+4 with no stall. Throughput is 1 beat/cycle.
- Single-beat pixel (first and last on the same beat) is legal.
- Back-to-back pixels: the next pixel's first beat may follow a last beat immediately, with no bubble and no carry-over.
- out_valid holds, and conv_dout/out_sat stay stable, until out_ready.
- Reset mid-pixel discards partial accumulation; the next accepted beat starts a new pixel.
- in_valid=0 inserts bubbles; they do not affect accumulation.

Decomposition:
- Shared package nn_pkg: clog2 function, sat_max/sat_min(N) constants, ACC_W minimum-check function, lane slice helper.
- One sub-module, sum_tree (parameters IN_CH, W_IN, W_OUT): combinational signed reduction, registered by the parent in S2.
- Multipliers are inline signed multiplies; the existing qmult latency is not used.

Test Plan:
- All parameter checks use N=16, IN_CH=4.
- Single beat, all lanes input=256, weight=256, bias=0, shift=8, relu_en=0 -> conv_dout=1024, out_sat=0, out_valid exactly 4 cycles after acceptance.
- Three beats with the same stimulus, in_last on the third -> one output, 3072. Next pixel follows with no bubble: one beat -> 1024.
- Lane 0 input=-256, weight=256, in_keep=4'b0001, shift=8: relu_en=0 -> -256; relu_en=1 -> 0 with out_sat=0.
- All lanes input=32767, weight=32767, shift=0 -> 32767 with out_sat=1. Negated weights -> -32768 with out_sat=1.
- Rounding, shift=8: accumulated 384 (via bias=384, keep=0) -> 2; bias=-384 -> -1.
- out_ready=0 for 3 cycles while 2 pixels stream: in_ready low, conv_dout stable, both results delivered in order. Then rst pulse after 2 beats of a 3-beat pixel -> out_valid=0 immediately, and the next 1-beat pixel gives 1024.
